// File: rtl/dpram_lsu_if.sv
// dpram_lsu_if: request/response handshake and RAM-port bus of the load/store unit.
// Request  : req_valid/req_ready, req_we, req_size, req_signed, req_addr, req_wdata
// Response : rsp_valid/rsp_ready, rsp_rdata, rsp_err
// RAM port : mem_addr, mem_wdata, mem_we (to RAM), mem_rdata (from RAM, combinational)
// slave modport is the unit itself; master is the requester plus RAM side.
interface dpram_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  rsp_ready, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_we
    );

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output rsp_ready, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/dpram_lsu.sv
// dpram_lsu: byte/half/word load-store unit in front of one port of a 64 KiB dual-port RAM.
// Ports: m_clock (clock), p_reset (sync active-high reset), bus (dpram_lsu_if.slave:
// request handshake in, response handshake out, RAM address/wdata/we out, RAM rdata in).
// The RAM always writes four bytes, so byte/half stores read the word first (MERGE)
// and write it back with only the addressed low bytes replaced (WRITE). The other RAM
// port is not interlocked between MERGE and WRITE; its bytes in that word may be lost.
module dpram_lsu #(
    parameter logic [31:0] ADDR_LIMIT = 32'h0000FFFC
) (
    input  logic        m_clock,
    input  logic        p_reset,
    dpram_lsu_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, LOAD, MERGE, WRITE, RESP} state_t;

    state_t      state_q;
    logic [1:0]  size_q;
    logic        sgn_q;
    logic        err_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] merge_q;
    logic [31:0] rdata_q;
    logic        err_d;
    logic [31:0] rdata_d;
    logic [31:0] merge_d;

    always_comb begin
        err_d   = bus.req_size == 2'b11
               || (bus.req_size == 2'b01 && bus.req_addr[0])
               || (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00)
               || bus.req_addr > ADDR_LIMIT;
        rdata_d = size_q == 2'b00 ? {{24{sgn_q & bus.mem_rdata[7]}}, bus.mem_rdata[7:0]}
                : size_q == 2'b01 ? {{16{sgn_q & bus.mem_rdata[15]}}, bus.mem_rdata[15:0]}
                : bus.mem_rdata;
        merge_d = size_q == 2'b00 ? {bus.mem_rdata[31:8], wdata_q[7:0]}
                : {bus.mem_rdata[31:16], wdata_q[15:0]};
    end

    always_ff @(posedge m_clock) begin
        if (p_reset) begin
            state_q <= IDLE;
            size_q  <= 2'b00;
            sgn_q   <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            merge_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (bus.req_valid) begin
                    size_q  <= bus.req_size;
                    sgn_q   <= bus.req_signed;
                    err_q   <= err_d;
                    addr_q  <= bus.req_addr;
                    wdata_q <= bus.req_wdata;
                    // word stores skip MERGE, so the write image is the request data itself
                    merge_q <= bus.req_wdata;
                    rdata_q <= '0;
                    state_q <= err_d ? RESP : !bus.req_we ? LOAD
                             : bus.req_size == 2'b10 ? WRITE : MERGE;
                end
                LOAD: begin
                    rdata_q <= rdata_d;
                    state_q <= RESP;
                end
                MERGE: begin
                    merge_q <= merge_d;
                    state_q <= WRITE;
                end
                WRITE: state_q <= RESP;
                RESP: if (bus.rsp_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = state_q == IDLE;
    assign bus.rsp_valid = state_q == RESP;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = state_q == WRITE ? merge_q : '0;
    // reset in WRITE must not let the pending write reach the RAM
    assign bus.mem_we    = state_q == WRITE && !p_reset;
endmodule

// File: tb/tb_dpram_lsu.sv
// tb_dpram_lsu: directed and random requests against a byte-array model of memory.
module tb_dpram_lsu;
    logic m_clock = 1'b0;
    logic p_reset = 1'b1;
    int checks = 0;
    int failures = 0;
    logic [7:0] ram [0:65535];
    logic [7:0] ref_mem [0:65535];
    logic [15:0] ra;

    dpram_lsu_if bus ();

    dpram_lsu dut (
        .m_clock (m_clock),
        .p_reset (p_reset),
        .bus     (bus.slave)
    );

    always #5 m_clock = ~m_clock;

    always_comb begin
        ra = bus.mem_addr[15:0];
        bus.mem_rdata = {ram[ra + 16'd3], ram[ra + 16'd2], ram[ra + 16'd1], ram[ra]};
    end

    always @(posedge m_clock) begin
        if (bus.mem_we) begin
            ram[ra]          <= bus.mem_wdata[7:0];
            ram[ra + 16'd1]  <= bus.mem_wdata[15:8];
            ram[ra + 16'd2]  <= bus.mem_wdata[23:16];
            ram[ra + 16'd3]  <= bus.mem_wdata[31:24];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Architectural effect of one request on byte memory, plus expected latency and write count.
    task automatic model(input logic we, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] d, output logic e,
                         output int lat, output int wes);
        int n;
        longint v;
        e = sz == 2'd3 || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) || a > 32'h0000FFFC;
        n = 1 << sz;
        d = '0;
        lat = e ? 1 : (we && sz != 2'd2) ? 3 : 2;
        wes = (!e && we) ? 1 : 0;
        if (!e) begin
            if (we) begin
                for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
            end else begin
                v = 0;
                for (int i = 0; i < n; i++) v += longint'(ref_mem[int'(a) + i]) << (8 * i);
                if (sg && sz != 2'd2 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
                d = v[31:0];
            end
        end
    endtask

    task automatic do_req(input logic we, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                          input logic [31:0] wd, input int hold, input string tag,
                          output logic [31:0] obs);
        logic [31:0] exp_d;
        logic exp_e;
        int exp_lat, exp_wes, lat, wes;
        model(we, sz, sg, a, wd, exp_d, exp_e, exp_lat, exp_wes);
        @(negedge m_clock);
        check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_we = we;
        bus.req_size = sz;
        bus.req_signed = sg;
        bus.req_addr = a;
        bus.req_wdata = wd;
        bus.rsp_ready = 1'b0;
        @(posedge m_clock);
        #1 bus.req_valid = 1'b0;
        lat = 0;
        wes = 0;
        while (lat < 20) begin
            @(negedge m_clock);
            lat++;
            if (bus.mem_we) wes++;
            if (bus.rsp_valid) break;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_we_cycles"}, 32'(wes), 32'(exp_wes));
        check({tag, "_rdata"}, bus.rsp_rdata, exp_d);
        check({tag, "_err"}, 32'(bus.rsp_err), 32'(exp_e));
        obs = bus.rsp_rdata;
        for (int i = 0; i < hold; i++) begin
            @(negedge m_clock);
            check({tag, "_hold_valid"}, 32'(bus.rsp_valid), 32'd1);
            check({tag, "_hold_rdata"}, bus.rsp_rdata, exp_d);
            check({tag, "_hold_req_ready"}, 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge m_clock);
        #1 bus.rsp_ready = 1'b0;
        @(negedge m_clock);
        check({tag, "_idle_after"}, {31'd0, bus.req_ready & ~bus.rsp_valid}, 32'd1);
    endtask

    initial begin
        logic [31:0] r, a;
        int mism, nv;
        bus.req_valid = 1'b0;
        bus.req_we = 1'b0;
        bus.req_size = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 65536; i++) begin
            ram[i] = 8'($urandom);
            ref_mem[i] = ram[i];
        end
        repeat (2) @(posedge m_clock);
        #1 p_reset = 1'b0;
        @(negedge m_clock);
        check("reset_req_ready", 32'(bus.req_ready), 32'd1);
        check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset_mem_we", 32'(bus.mem_we), 32'd0);
        check("reset_mem_addr", bus.mem_addr, 32'd0);
        check("reset_mem_wdata", bus.mem_wdata, 32'd0);
        check("reset_rsp_rdata", bus.rsp_rdata, 32'd0);

        do_req(1'b1, 2'd2, 1'b0, 32'h0100, 32'hDEADBEEF, 0, "sw", r);
        do_req(1'b0, 2'd2, 1'b0, 32'h0100, 32'h0, 0, "lw", r);
        check("lw_const", r, 32'hDEADBEEF);
        do_req(1'b1, 2'd0, 1'b0, 32'h0101, 32'h00000080, 0, "sb", r);
        do_req(1'b0, 2'd2, 1'b0, 32'h0100, 32'h0, 0, "lw2", r);
        check("lw2_const", r, 32'hDEAD80EF);
        do_req(1'b0, 2'd0, 1'b1, 32'h0101, 32'h0, 0, "lbs", r);
        check("lbs_const", r, 32'hFFFFFF80);
        do_req(1'b0, 2'd0, 1'b0, 32'h0101, 32'h0, 0, "lbu", r);
        check("lbu_const", r, 32'h00000080);
        do_req(1'b1, 2'd1, 1'b0, 32'h0102, 32'h00001234, 0, "sh", r);
        do_req(1'b0, 2'd1, 1'b1, 32'h0102, 32'h0, 0, "lhs", r);
        check("lhs_const", r, 32'h00001234);
        do_req(1'b0, 2'd1, 1'b0, 32'h0103, 32'h0, 0, "lh_mis", r);
        do_req(1'b0, 2'd2, 1'b0, 32'h0000FFFD, 32'h0, 0, "lw_range", r);
        do_req(1'b0, 2'd3, 1'b0, 32'h0, 32'h0, 0, "size3", r);
        do_req(1'b1, 2'd2, 1'b0, 32'h00010000, 32'hCAFEF00D, 0, "sw_range", r);
        do_req(1'b1, 2'd2, 1'b0, 32'h0000FFFC, 32'hA5A55A5A, 0, "sw_top", r);
        do_req(1'b0, 2'd2, 1'b0, 32'h0100, 32'h0, 5, "lw_hold", r);

        @(negedge m_clock);
        bus.req_valid = 1'b1;
        bus.req_we = 1'b1;
        bus.req_size = 2'd2;
        bus.req_signed = 1'b0;
        bus.req_addr = 32'h0200;
        bus.req_wdata = 32'h11223344;
        @(posedge m_clock);
        #1 bus.req_valid = 1'b0;
        p_reset = 1'b1;
        @(negedge m_clock);
        check("rst_write_we", 32'(bus.mem_we), 32'd0);
        @(posedge m_clock);
        #1 p_reset = 1'b0;
        @(negedge m_clock);
        check("rst_write_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_write_mem_addr", bus.mem_addr, 32'd0);
        check("rst_write_mem_wdata", bus.mem_wdata, 32'd0);
        nv = 0;
        repeat (3) begin
            @(negedge m_clock);
            if (bus.rsp_valid) nv++;
        end
        check("rst_write_no_rsp", 32'(nv), 32'd0);
        do_req(1'b0, 2'd2, 1'b0, 32'h0200, 32'h0, 0, "lw_after_rst", r);

        for (int k = 0; k < 60; k++) begin
            case ($urandom_range(0, 4))
                0: a = 32'h0300 + 32'($urandom_range(0, 63));
                1: a = 32'h0000FFF8 + 32'($urandom_range(0, 7));
                2: a = $urandom;
                default: a = 32'h0300 + 32'(4 * $urandom_range(0, 15));
            endcase
            do_req(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), a, $urandom,
                   ($urandom_range(0, 7) == 0) ? 2 : 0, "rnd", r);
        end

        mism = 0;
        for (int i = 0; i < 65536; i++) if (ram[i] !== ref_mem[i]) mism++;
        check("final_memory", 32'(mism), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dpram_lsu.md
# dpram_lsu

Load/store unit sitting directly upstream of one port of the 64 KiB byte-addressed dual-port RAM. Accepts byte/halfword/word load and store requests over a valid/ready handshake, drives the RAM port's address, write data and write enable, and returns sign- or zero-extended load data over a valid/ready response channel. The RAM port always writes four bytes at `addr..addr+3`, so sub-word stores are performed as read-modify-write. Misaligned, out-of-range or illegal-size requests are rejected with an error response and never touch memory.

## Interface
- `ADDR_LIMIT`, 32'h0000FFFC: highest legal request address; keeps the 4-byte RAM window inside 64 KiB.
- `m_clock`  in  1  sole clock; all state updates on the rising edge.
- `p_reset`  in  1  reset; synchronous and active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request (high only in IDLE).
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- `req_signed`  in  1  sign-extend load data; ignored for word loads and stores.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_rdata`  out  32  extended load data; 0 for stores and errors.
- `rsp_err`  out  1  request rejected.
- `mem_addr`  out  32  to RAM port address.
- `mem_wdata`  out  32  to RAM port write data.
- `mem_we`  out  1  to RAM port write enable.
- `mem_rdata`  in  32  from RAM port; combinational read of bytes addr+3..addr.

## Operation
- States: IDLE, LOAD, MERGE, WRITE, RESP.
- IDLE: `req_ready`=1. On `req_valid`: latch we, size, signed, addr, wdata; compute err.
- err = size==11, or (size==01 and addr[0]), or (size==10 and addr[1:0]!=0), or addr > `ADDR_LIMIT` (unsigned).
- IDLE transitions: err -> RESP; load -> LOAD; word store -> WRITE; byte/half store -> MERGE.
- LOAD: `mem_addr`=latched addr; capture `mem_rdata`, select low 8/16/32 bits, extend (sign if signed, else zero) into `rsp_rdata`; -> RESP.
- MERGE: `mem_addr`=latched addr; merge register = {`mem_rdata`[31:8], wdata[7:0]} for byte, {`mem_rdata`[31:16], wdata[15:0]} for half; -> WRITE.
- WRITE: `mem_we`=1, `mem_wdata`=merge register (word store: latched wdata); -> RESP.
- RESP: `rsp_valid`=1, `rsp_rdata`/`rsp_err` held stable; on `rsp_ready` -> IDLE. Request in the same cycle is not accepted (`req_ready`=0 in RESP).
- `mem_addr` = latched address register in all states; `mem_wdata`=0 and `mem_we`=0 outside WRITE.
- `mem_we` = (state==WRITE) && !`p_reset`; reset during WRITE suppresses the write.
- Other port of the RAM may write the same bytes between MERGE and WRITE; no interlock, its bytes may be overwritten (documented limitation).

## Timing
- Reset (any state): state IDLE; `req_ready`=1 in the following cycle; `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `mem_we`=0, `mem_wdata`=0, `mem_addr`=0; in-flight request dropped, no response.
- Request accepted at edge ending cycle T (`req_valid`&&`req_ready`).
- Error: `rsp_valid` in T+1.
- Load: LOAD in T+1, `rsp_valid` in T+2.
- Word store: `mem_we` in T+1 (RAM updated at end of T+1), `rsp_valid` in T+2.
- Byte/half store: MERGE T+1, `mem_we` T+2, `rsp_valid` T+3.
- `rsp_valid` held with constant data until `rsp_ready`; back-to-back throughput one request per 3/3/4/2 cycles (load/word store/sub-word store/error) with `rsp_ready` held high.

## Test plan
- Word store 0xDEADBEEF @0x0100, then word load @0x0100 -> `mem_we` one cycle, rsp after 2 cycles each, load `rsp_rdata`=0xDEADBEEF, `rsp_err`=0.
- Byte store 0x80 @0x0101 over that word, then word load @0x0100 -> 0xDEAD80EF; signed byte load @0x0101 -> 0xFFFFFF80; unsigned -> 0x00000080.
- Half store 0x1234 @0x0102, signed half load @0x0102 -> 0x00001234; half load @0x0103 -> `rsp_err`=1, `rsp_rdata`=0, no `mem_we`.
- Word load @0x0000FFFD, size 11 @0x0, word store @0x00010000 -> each `rsp_err`=1 after 1 cycle, memory unchanged.
- Hold `rsp_ready`=0 for 5 cycles after a load -> `rsp_valid`, `rsp_rdata` stable, `req_ready`=0; release -> IDLE next cycle.
- Assert `p_reset` during WRITE of a word store 0x11223344 @0x0200 -> `mem_we` stays 0, no response, subsequent load @0x0200 returns prior contents.
